// File: rtl/rv32i_pkg.sv
// Shared RV32I fetch definitions.
//   XLEN / INSTR_W     datapath and instruction widths
//   DEFAULT_RESET_PC   default PC loaded on reset
//   RV_NOP             canonical NOP (addi x0, x0, 0), shown on dec_instr when the buffer is empty
//   fetch_state_e      fetch FSM states
//   fetch_entry_t      {pc, instr} pair held in the fetch buffer
package rv32i_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] RV_NOP           = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for fetched {pc, instr} entries.
//   clk, rst    clock and synchronous active-high reset
//   flush       empties the FIFO; wins over a same-cycle push or pop
//   push        write push_data at the tail
//   push_data   entry to write
//   pop         drop the head entry
//   head_data   registered head entry (no bypass from push_data)
//   count       number of valid entries
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Guard against over/underflow even though the fetch FSM never requests either.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates visibility of every slot.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem reads,
// and a small {pc, instr} buffer toward decode.
//   clk, rst                              clock, synchronous active-high reset
//   redirect_valid, redirect_pc           taken-branch redirect (target word-aligned on load)
//   fetch_pc                              current PC, fed back to next_pc
//   imem_req_valid/ready, imem_req_addr   read request handshake
//   imem_rsp_valid, imem_rsp_data         read response
//   dec_valid/ready, dec_pc, dec_instr    buffer head toward decode
module if_fetch_unit
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic [XLEN-1:0]    fetch_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [XLEN-1:0]    dec_pc,
    output logic [INSTR_W-1:0] dec_instr
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q, req_pc_d;
    logic [CNT_W-1:0] fifo_count;
    logic             req_fire, fifo_push, fifo_pop;
    fetch_entry_t     push_entry, head_entry;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_REQ;
        else     state_q <= state_d;
    end

    // Next state; a redirect overrides normal sequencing, but an in-flight
    // request must still be drained (S_DROP) unless its response is here now.
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            unique case (state_q)
                S_WAIT, S_DROP: state_d = imem_rsp_valid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ:   if (req_fire) state_d = S_WAIT;
                S_WAIT:  if (imem_rsp_valid) state_d = S_REQ;
                S_DROP:  if (imem_rsp_valid) state_d = S_REQ;
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs; a request only issues with a free slot, which reserves it for the response.
    always_comb begin
        imem_req_valid = 1'b0;
        fifo_push      = 1'b0;
        unique case (state_q)
            S_REQ:   imem_req_valid = !redirect_valid && (fifo_count < CNT_W'(FIFO_DEPTH));
            S_WAIT:  fifo_push = imem_rsp_valid && !redirect_valid;
            default: ;
        endcase
    end

    assign req_fire = imem_req_valid && imem_req_ready;

    always_comb begin
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end else if (req_fire) begin
            pc_d     = pc_q + XLEN'(4);
            req_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign fetch_pc      = pc_q;
    assign imem_req_addr = pc_q;

    assign push_entry = '{pc: req_pc_q, instr: imem_rsp_data};
    assign fifo_pop   = dec_valid && dec_ready;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count)
    );

    assign dec_valid = (fifo_count != '0);
    assign dec_pc    = head_entry.pc;
    assign dec_instr = dec_valid ? head_entry.instr : RV_NOP;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural imem with programmable response delay,
// scoreboard queue of expected {pc, instr} beats, per-cycle vector table and
// hand-written corner-case sequences.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_instr;

    always #5 clk = ~clk;

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_pc       (fetch_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_instr      (dec_instr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } beat_t;

    typedef struct {
        logic        req_valid;
        logic [31:0] req_addr;
        logic        dec_valid;
        logic [31:0] dec_pc;
    } vec_t;

    beat_t       sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rsp_delay = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_wait = 0;
    bit          fire_s = 1'b0;
    bit          rsp_s = 1'b0;
    logic [31:0] fire_addr = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Mid-cycle: sample handshakes and run the scoreboard.
    task automatic to_neg();
        beat_t e;
        @(negedge clk);
        fire_s    = imem_req_valid && imem_req_ready && !rst;
        fire_addr = imem_req_addr;
        rsp_s     = imem_rsp_valid;
        if (redirect_valid && !rst) chk("no_req_on_redirect", 32'(imem_req_valid), 32'd0);
        if (dec_valid && dec_ready && !rst) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: got beat pc %h expected none", dec_pc);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", dec_pc, e.pc);
                chk("sb_instr", dec_instr, e.instr);
            end
        end
        if (redirect_valid || rst) sb.delete();
        else if (fire_s) sb.push_back('{pc: fire_addr, instr: mem_word(fire_addr)});
    endtask

    // Just after the edge: advance the imem model and drive its response.
    task automatic to_next();
        @(posedge clk);
        #1;
        if (rsp_s) pend = 1'b0;
        if (fire_s) begin
            pend      = 1'b1;
            pend_addr = fire_addr;
            pend_wait = rsp_delay - 1;
        end else if (pend && pend_wait > 0) begin
            pend_wait--;
        end
        imem_rsp_valid = pend && (pend_wait == 0);
        imem_rsp_data  = pend ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    endtask

    task automatic tick();
        to_neg();
        to_next();
    endtask

    task automatic do_reset(input logic rdy);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = rdy;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend           = 1'b0;
        rsp_delay      = 1;
        sb.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t1[7];
        int   n;
        t1[0] = '{1'b1, 32'h0, 1'b0, 32'h0};
        t1[1] = '{1'b0, 32'h0, 1'b0, 32'h0};
        t1[2] = '{1'b1, 32'h4, 1'b1, 32'h0};
        t1[3] = '{1'b0, 32'h0, 1'b0, 32'h0};
        t1[4] = '{1'b1, 32'h8, 1'b1, 32'h4};
        t1[5] = '{1'b0, 32'h0, 1'b0, 32'h0};
        t1[6] = '{1'b1, 32'hC, 1'b1, 32'h8};

        // T1: reset state and zero-wait streaming
        do_reset(1'b1);
        for (int i = 0; i < 7; i++) begin
            to_neg();
            if (i == 0) chk("t1_reset_fetch_pc", fetch_pc, 32'h0);
            chk($sformatf("t1_req_valid[%0d]", i), 32'(imem_req_valid), 32'(t1[i].req_valid));
            if (t1[i].req_valid) chk($sformatf("t1_req_addr[%0d]", i), imem_req_addr, t1[i].req_addr);
            chk($sformatf("t1_dec_valid[%0d]", i), 32'(dec_valid), 32'(t1[i].dec_valid));
            if (t1[i].dec_valid) chk($sformatf("t1_dec_pc[%0d]", i), dec_pc, t1[i].dec_pc);
            to_next();
        end

        // T2: decode stalled, buffer fills, then drains in order
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) tick();
        to_neg();
        chk("t2_full_dec_valid", 32'(dec_valid), 32'd1);
        chk("t2_full_head_pc", dec_pc, 32'h0);
        chk("t2_full_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_full_fetch_pc", fetch_pc, 32'h8);
        to_next();
        dec_ready = 1'b1;
        to_neg();
        chk("t2_drain0_pc", dec_pc, 32'h0);
        chk("t2_drain0_req_valid", 32'(imem_req_valid), 32'd0);
        to_next();
        to_neg();
        chk("t2_drain1_pc", dec_pc, 32'h4);
        chk("t2_resume_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t2_resume_addr", imem_req_addr, 32'h8);
        to_next();
        to_neg();
        chk("t2_empty", 32'(dec_valid), 32'd0);
        to_next();
        n = 0;
        to_neg();
        while (!dec_valid && n < 10) begin
            to_next();
            to_neg();
            n++;
        end
        chk("t2_resumed_beat_valid", 32'(dec_valid), 32'd1);
        chk("t2_resumed_beat_pc", dec_pc, 32'h8);
        to_next();

        // T3: redirect while waiting on a late response
        do_reset(1'b1);
        rsp_delay = 3;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        rsp_delay      = 1;
        to_neg();
        chk("t3_fetch_pc", fetch_pc, 32'h100);
        chk("t3_flushed", 32'(dec_valid), 32'd0);
        chk("t3_drop_no_req", 32'(imem_req_valid), 32'd0);
        to_next();
        to_neg();
        chk("t3_drop_rsp_no_req", 32'(imem_req_valid), 32'd0);
        to_next();
        to_neg();
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h100);
        chk("t3_late_rsp_discarded", 32'(dec_valid), 32'd0);
        to_next();
        tick();
        to_neg();
        chk("t3_target_beat_valid", 32'(dec_valid), 32'd1);
        chk("t3_target_beat_pc", dec_pc, 32'h100);
        to_next();

        // T4: redirect together with a response and a decode pop
        do_reset(1'b0);
        tick();
        tick();
        tick();
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        to_neg();
        chk("t4_head_present", 32'(dec_valid), 32'd1);
        to_next();
        redirect_valid = 1'b0;
        to_neg();
        chk("t4_no_push", 32'(dec_valid), 32'd0);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h200);
        to_next();
        to_neg();
        chk("t4_wait_empty", 32'(dec_valid), 32'd0);
        to_next();
        to_neg();
        chk("t4_target_beat_pc", dec_pc, 32'h200);
        chk("t4_target_beat_valid", 32'(dec_valid), 32'd1);
        to_next();

        // T5: PC wraps past the top of the address space
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        to_neg();
        chk("t5_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        to_next();
        to_neg();
        chk("t5_wrapped_pc", fetch_pc, 32'h0);
        to_next();
        to_neg();
        chk("t5_beat_pc", dec_pc, 32'hFFFF_FFFC);
        chk("t5_beat_instr", dec_instr, 32'h5A5A_FFFC);
        to_next();

        // T6: reset while waiting; stale response lands right after reset
        do_reset(1'b1);
        rsp_delay = 2;
        tick();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        rsp_delay = 1;
        to_neg();
        chk("t6_stale_rsp_present", 32'(imem_rsp_valid), 32'd1);
        chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req_addr", imem_req_addr, 32'h0);
        chk("t6_dec_empty", 32'(dec_valid), 32'd0);
        to_next();
        to_neg();
        chk("t6_stale_ignored", 32'(dec_valid), 32'd0);
        to_next();
        to_neg();
        chk("t6_first_beat_valid", 32'(dec_valid), 32'd1);
        chk("t6_first_beat_pc", dec_pc, 32'h0);
        to_next();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
